dmem_mmio_responder: RTL and testbench

//  Data-side responder for the single-cycle MIPS core: answers every load/store the core

---
 rtl/dmem_mmio_responder_if.sv | 31 +++
 rtl/dmem_mmio_responder.sv | 186 ++++++++++++++++++
 tb/tb_dmem_mmio_responder.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_mmio_responder_if.sv
// Core data-port and console-stream bundle for dmem_mmio_responder.
// The master side is the core plus console sink; the slave side is the responder.
interface dmem_mmio_responder_if;
  logic        MemWrite;
  logic [31:0] ALUresult;
  logic [31:0] WriteDataMem;
  logic [31:0] ReadDataMem;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        con_ready;

  modport master (
    output MemWrite,
    output ALUresult,
    output WriteDataMem,
    output con_ready,
    input  ReadDataMem,
    input  con_valid,
    input  con_data
  );

  modport slave (
    input  MemWrite,
    input  ALUresult,
    input  WriteDataMem,
    input  con_ready,
    output ReadDataMem,
    output con_valid,
    output con_data
  );
endinterface

// File: rtl/dmem_mmio_responder.sv
// Data-side responder for the single-cycle MIPS core: word RAM plus an MMIO page
// holding a console TX FIFO, a free-running cycle counter and a halt register.
module dmem_mmio_responder #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  CLK,
  input  logic                  reset,
  dmem_mmio_responder_if.slave  bus,
  output logic                  halt,
  output logic [7:0]            halt_code,
  output logic                  addr_err
);

  localparam int RAM_AW  = $clog2(RAM_WORDS);
  localparam int FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = FIFO_AW + 1;

  localparam logic [29:0] CON_TX_WA = 30'h3FFF_C000;
  localparam logic [29:0] STAT_WA   = 30'h3FFF_C001;
  localparam logic [29:0] CYCLE_WA  = 30'h3FFF_C002;
  localparam logic [29:0] HALT_WA   = 30'h3FFF_C003;

  logic [31:0]        ram_r [RAM_WORDS];
  logic [7:0]         fifo_mem_r [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_r;
  logic [FIFO_AW-1:0] rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               ovf_r;
  logic               con_valid_r;
  logic [7:0]         con_data_r;
  logic [31:0]        cycle_r;
  logic               halt_r;
  logic [7:0]         halt_code_r;
  logic               addr_err_r;

  logic [29:0]        word_addr_s;
  logic [RAM_AW-1:0]  ram_idx_s;
  logic               ram_hit_s;
  logic               con_tx_hit_s;
  logic               stat_hit_s;
  logic               cycle_hit_s;
  logic               halt_hit_s;
  logic               mapped_s;
  logic               wr_en_s;
  logic               ram_we_s;
  logic               push_req_s;
  logic               push_s;
  logic               pop_s;
  logic               full_s;
  logic               empty_s;
  logic               ovf_set_s;
  logic [CNT_W-1:0]   count_next_s;
  logic [FIFO_AW-1:0] wr_ptr_next_s;
  logic [FIFO_AW-1:0] rd_ptr_next_s;
  logic [7:0]         head_next_s;
  logic [7:0]         stat_count_s;
  logic [31:0]        rdata_s;
  logic               addr_lsb_unused_s;

  assign addr_lsb_unused_s = ^bus.ALUresult[1:0];

  // Address decode and store qualification; halted or reset cycles commit no stores.
  always_comb begin
    word_addr_s  = bus.ALUresult[31:2];
    ram_idx_s    = bus.ALUresult[RAM_AW+1:2];
    ram_hit_s    = (bus.ALUresult[31:RAM_AW+2] == {(30-RAM_AW){1'b0}});
    con_tx_hit_s = (word_addr_s == CON_TX_WA);
    stat_hit_s   = (word_addr_s == STAT_WA);
    cycle_hit_s  = (word_addr_s == CYCLE_WA);
    halt_hit_s   = (word_addr_s == HALT_WA);
    mapped_s     = ram_hit_s | con_tx_hit_s | stat_hit_s | cycle_hit_s | halt_hit_s;
    wr_en_s      = bus.MemWrite & ~halt_r;
    ram_we_s     = wr_en_s & ram_hit_s & ~reset;
  end

  // FIFO control: a push into a full FIFO only lands when the head leaves on the same edge.
  always_comb begin
    empty_s       = (count_r == {CNT_W{1'b0}});
    full_s        = (count_r == CNT_W'(FIFO_DEPTH));
    push_req_s    = wr_en_s & con_tx_hit_s;
    pop_s         = con_valid_r & bus.con_ready;
    push_s        = push_req_s & (~full_s | pop_s);
    ovf_set_s     = push_req_s & full_s & ~pop_s;
    wr_ptr_next_s = push_s ? (wr_ptr_r + {{(FIFO_AW-1){1'b0}}, 1'b1}) : wr_ptr_r;
    rd_ptr_next_s = pop_s ? (rd_ptr_r + {{(FIFO_AW-1){1'b0}}, 1'b1}) : rd_ptr_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      2'b01:   count_next_s = count_r - {{(CNT_W-1){1'b0}}, 1'b1};
      default: count_next_s = count_r;
    endcase
    // The byte written this edge becomes the head when it lands in the next read slot.
    if (push_s && (wr_ptr_r == rd_ptr_next_s)) begin
      head_next_s = bus.WriteDataMem[7:0];
    end else begin
      head_next_s = fifo_mem_r[rd_ptr_next_s];
    end
  end

  // Load data mux; CON_TX and unmapped addresses read as zero.
  always_comb begin
    stat_count_s = 8'(count_r);
    rdata_s      = 32'h0000_0000;
    if (ram_hit_s) begin
      rdata_s = ram_r[ram_idx_s];
    end else if (stat_hit_s) begin
      rdata_s = {16'h0000, stat_count_s, 5'b00000, ovf_r, empty_s, full_s};
    end else if (cycle_hit_s) begin
      rdata_s = cycle_r;
    end else if (halt_hit_s) begin
      rdata_s = {23'h000000, halt_r, halt_code_r};
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  // Data RAM: contents are deliberately left unreset.
  always_ff @(posedge CLK) begin
    if (ram_we_s) begin
      ram_r[ram_idx_s] <= bus.WriteDataMem;
    end
  end

  // Console FIFO storage, pointers, occupancy and registered head.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= 8'h00;
      end
      wr_ptr_r    <= {FIFO_AW{1'b0}};
      rd_ptr_r    <= {FIFO_AW{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      ovf_r       <= 1'b0;
      con_valid_r <= 1'b0;
      con_data_r  <= 8'h00;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= bus.WriteDataMem[7:0];
      end
      wr_ptr_r    <= wr_ptr_next_s;
      rd_ptr_r    <= rd_ptr_next_s;
      count_r     <= count_next_s;
      ovf_r       <= ovf_r | ovf_set_s;
      con_valid_r <= (count_next_s != {CNT_W{1'b0}});
      con_data_r  <= head_next_s;
    end
  end

  // Cycle counter: a CYCLE store overrides the increment; frozen once halted.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      cycle_r <= 32'h0000_0000;
    end else if (!halt_r) begin
      if (bus.MemWrite && cycle_hit_s) begin
        cycle_r <= 32'h0000_0000;
      end else begin
        cycle_r <= cycle_r + 32'h0000_0001;
      end
    end
  end

  // Halt latch and sticky store-to-unmapped flag.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      halt_r      <= 1'b0;
      halt_code_r <= 8'h00;
      addr_err_r  <= 1'b0;
    end else begin
      if (wr_en_s && halt_hit_s) begin
        halt_r      <= 1'b1;
        halt_code_r <= bus.WriteDataMem[7:0];
      end
      if (wr_en_s && !mapped_s) begin
        addr_err_r <= 1'b1;
      end
    end
  end

  assign bus.ReadDataMem = rdata_s;
  assign bus.con_valid   = con_valid_r;
  assign bus.con_data    = con_data_r;
  assign halt            = halt_r;
  assign halt_code       = halt_code_r;
  assign addr_err        = addr_err_r;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder: vector table for RAM/decode plus
// hand-written sequences for the FIFO, counter, halt and reset corner cases.
module tb_dmem_mmio_responder;

  logic       CLK;
  logic       reset;
  logic       halt;
  logic [7:0] halt_code;
  logic       addr_err;

  int checks;
  int errors;

  dmem_mmio_responder_if bus ();

  dmem_mmio_responder #(.RAM_WORDS(64), .FIFO_DEPTH(8)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .bus       (bus),
    .halt      (halt),
    .halt_code (halt_code),
    .addr_err  (addr_err)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [18];

  localparam logic [31:0] A_TX    = 32'hFFFF_0000;
  localparam logic [31:0] A_STAT  = 32'hFFFF_0004;
  localparam logic [31:0] A_CYCLE = 32'hFFFF_0008;
  localparam logic [31:0] A_HALT  = 32'hFFFF_000C;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  // Drive one bus access just after a falling edge; it commits at the next rising edge.
  task automatic drv(input logic we, input logic [31:0] a, input logic [31:0] d);
    @(negedge CLK);
    bus.MemWrite     = we;
    bus.ALUresult    = a;
    bus.WriteDataMem = d;
    #1;
  endtask

  logic [7:0] exp_q [8];

  initial begin
    checks = 0;
    errors = 0;
    CLK = 1'b0;
    reset = 1'b1;
    bus.MemWrite = 1'b0;
    bus.ALUresult = A_CYCLE;
    bus.WriteDataMem = 32'h0;
    bus.con_ready = 1'b0;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b1, 32'h0000_0000, 32'h1234_5678, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 32'h0000_0004, 32'h0000_1111, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h1234_5678};
    vecs[6]  = '{1'b0, 32'h0000_0004, 32'h0,         1'b1, 32'h0000_1111};
    vecs[7]  = '{1'b1, 32'h0000_00FC, 32'hA5A5_A5A5, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 32'h0000_00FC, 32'h0,         1'b1, 32'hA5A5_A5A5};
    vecs[9]  = '{1'b0, 32'h0000_0100, 32'h0,         1'b1, 32'h0};
    vecs[10] = '{1'b0, A_TX,          32'h0,         1'b1, 32'h0};
    vecs[11] = '{1'b0, A_STAT,        32'h0,         1'b1, 32'h0000_0002};
    vecs[12] = '{1'b0, A_HALT,        32'h0,         1'b1, 32'h0};
    vecs[13] = '{1'b0, 32'hFFFF_0010, 32'h0,         1'b1, 32'h0};
    vecs[14] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0};
    vecs[15] = '{1'b1, 32'h0000_0010, 32'h0BAD_F00D, 1'b1, 32'hDEAD_BEEF};
    vecs[16] = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'h0BAD_F00D};
    vecs[17] = '{1'b0, 32'h0000_0110, 32'h0,         1'b1, 32'h0};

    // Reset state and counter start
    @(negedge CLK);
    reset = 1'b0;
    #1;
    chk("rst_halt", {31'h0, halt}, 32'h0);
    chk("rst_code", {24'h0, halt_code}, 32'h0);
    chk("rst_addr_err", {31'h0, addr_err}, 32'h0);
    chk("rst_con_valid", {31'h0, bus.con_valid}, 32'h0);
    chk("rst_con_data", {24'h0, bus.con_data}, 32'h0);
    chk("rst_cycle", bus.ReadDataMem, 32'h0);
    repeat (5) drv(1'b0, A_CYCLE, 32'h0);
    chk("cycle_after5", bus.ReadDataMem, 32'd5);
    drv(1'b1, A_CYCLE, 32'hFFFF_FFFF);
    drv(1'b0, A_CYCLE, 32'h0);
    chk("cycle_cleared", bus.ReadDataMem, 32'd0);
    drv(1'b0, A_CYCLE, 32'h0);
    chk("cycle_clear_plus1", bus.ReadDataMem, 32'd1);

    // RAM and decode table
    for (int i = 0; i < 18; i++) begin
      drv(vecs[i].we, vecs[i].addr, vecs[i].wdata);
      if (vecs[i].chk) chk($sformatf("vec%0d_rdata", i), bus.ReadDataMem, vecs[i].exp);
    end
    drv(1'b0, A_STAT, 32'h0);
    chk("no_err_after_reads", {31'h0, addr_err}, 32'h0);

    // FIFO fill past full, then drain in order
    exp_q = '{8'h48, 8'h69, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
    for (int i = 0; i < 8; i++) drv(1'b1, A_TX, {24'h0, exp_q[i]});
    drv(1'b0, A_STAT, 32'h0);
    chk("fifo_full_stat", bus.ReadDataMem, 32'h0000_0801);
    chk("fifo_head_H", {24'h0, bus.con_data}, 32'h48);
    drv(1'b1, A_TX, 32'h36);
    drv(1'b0, A_STAT, 32'h0);
    chk("fifo_ovf_stat", bus.ReadDataMem, 32'h0000_0805);
    bus.con_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d_valid", i), {31'h0, bus.con_valid}, 32'h1);
      chk($sformatf("drain%0d_data", i), {24'h0, bus.con_data}, {24'h0, exp_q[i]});
      @(negedge CLK);
      #1;
    end
    chk("drain_empty", {31'h0, bus.con_valid}, 32'h0);
    bus.con_ready = 1'b0;
    drv(1'b0, A_STAT, 32'h0);
    chk("drain_stat", bus.ReadDataMem, 32'h0000_0006);

    // Full FIFO with push and pop on the same edge
    @(negedge CLK);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) drv(1'b1, A_TX, 32'h50 + i);
    drv(1'b1, A_TX, 32'h41);
    bus.con_ready = 1'b1;
    chk("simul_head", {24'h0, bus.con_data}, 32'h50);
    drv(1'b0, A_STAT, 32'h0);
    chk("simul_stat", bus.ReadDataMem, 32'h0000_0801);
    chk("simul_head2", {24'h0, bus.con_data}, 32'h51);
    exp_q = '{8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h41, 8'h00};
    for (int i = 0; i < 7; i++) begin
      @(negedge CLK);
      #1;
      chk($sformatf("simul_drain%0d", i), {23'h0, bus.con_valid, bus.con_data}, {23'h0, 1'b1, exp_q[i]});
    end
    @(negedge CLK);
    #1;
    chk("simul_empty", {31'h0, bus.con_valid}, 32'h0);
    bus.con_ready = 1'b0;

    // Counter wrap through a backdoor preset
    @(negedge CLK);
    bus.MemWrite = 1'b0;
    bus.ALUresult = A_CYCLE;
    force dut.cycle_r = 32'hFFFF_FFFF;
    #1;
    chk("cycle_preset", bus.ReadDataMem, 32'hFFFF_FFFF);
    release dut.cycle_r;
    @(negedge CLK);
    #1;
    chk("cycle_wrap", bus.ReadDataMem, 32'h0);

    // Mapped-but-ignored store, then unmapped store
    drv(1'b1, A_STAT, 32'hFFFF_FFFF);
    drv(1'b0, A_STAT, 32'h0);
    chk("stat_store_ignored", {bus.ReadDataMem[31:1], addr_err}, 32'h0000_0002);
    drv(1'b1, 32'h8000_0000, 32'h1111_1111);
    drv(1'b0, 32'h8000_0000, 32'h0);
    chk("unmapped_err", {31'h0, addr_err}, 32'h1);
    chk("unmapped_read", bus.ReadDataMem, 32'h0);
    drv(1'b0, 32'h0000_0000, 32'h0);
    chk("unmapped_no_alias", bus.ReadDataMem, 32'h1234_5678);

    // Halt: later stores ignored, counter frozen, FIFO still drains
    drv(1'b1, A_TX, 32'h77);
    drv(1'b1, A_TX, 32'h78);
    drv(1'b1, A_CYCLE, 32'h0);
    drv(1'b1, A_HALT, 32'h0000_012A);
    drv(1'b0, A_HALT, 32'h0);
    chk("halt_flag", {31'h0, halt}, 32'h1);
    chk("halt_code", {24'h0, halt_code}, 32'h2A);
    chk("halt_read", bus.ReadDataMem, 32'h0000_012A);
    drv(1'b1, 32'h0000_0000, 32'hFFFF_FFFF);
    drv(1'b0, 32'h0000_0000, 32'h0);
    chk("halt_ram_kept", bus.ReadDataMem, 32'h1234_5678);
    drv(1'b0, A_CYCLE, 32'h0);
    chk("halt_cycle", bus.ReadDataMem, 32'd1);
    drv(1'b1, A_CYCLE, 32'h0);
    drv(1'b0, A_CYCLE, 32'h0);
    chk("halt_cycle_frozen", bus.ReadDataMem, 32'd1);
    drv(1'b1, A_HALT, 32'h55);
    drv(1'b0, A_HALT, 32'h0);
    chk("halt_code_kept", bus.ReadDataMem, 32'h0000_012A);
    drv(1'b1, A_TX, 32'h99);
    drv(1'b0, A_STAT, 32'h0);
    chk("halt_push_ignored", bus.ReadDataMem, 32'h0000_0200);
    bus.con_ready = 1'b1;
    chk("halt_head", {24'h0, bus.con_data}, 32'h77);
    @(negedge CLK);
    bus.con_ready = 1'b0;
    #1;
    chk("halt_drained_one", {23'h0, bus.con_valid, bus.con_data}, 32'h0000_0178);

    // Asynchronous reset between edges; a store seen while reset is high is lost
    bus.MemWrite = 1'b1;
    bus.ALUresult = 32'h0000_0004;
    bus.WriteDataMem = 32'h0000_CAFE;
    #1;
    reset = 1'b1;
    #1;
    chk("arst_halt", {23'h0, halt, halt_code}, 32'h0);
    chk("arst_addr_err", {31'h0, addr_err}, 32'h0);
    chk("arst_con", {23'h0, bus.con_valid, bus.con_data}, 32'h0);
    bus.ALUresult = A_CYCLE;
    #1;
    chk("arst_cycle", bus.ReadDataMem, 32'h0);
    bus.ALUresult = 32'h0000_0004;
    @(negedge CLK);
    bus.MemWrite = 1'b0;
    reset = 1'b0;
    #1;
    chk("arst_store_lost", bus.ReadDataMem, 32'h0000_1111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
